// File: rtl/tcp_pkg.sv
// tcp_pkg: types, constants and sequence helper shared by the TCP sender and receive model.
package tcp_pkg;
    localparam int TCP_SEQ_W = 4;
    localparam logic [TCP_SEQ_W-1:0] SEQ_MASK = 4'd7;
    localparam logic [TCP_SEQ_W-1:0] WND_MAX = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_PERSIST
    } snd_state_t;

    function automatic logic [TCP_SEQ_W-1:0] seq_diff(
        input logic [TCP_SEQ_W-1:0] a,
        input logic [TCP_SEQ_W-1:0] b
    );
        return (a - b) & SEQ_MASK;
    endfunction
endpackage

// File: rtl/tcp_snd_timer.sv
// tcp_snd_timer: retransmit/persist counter; expires when it reaches RTO, clear has priority.
module tcp_snd_timer
    import tcp_pkg::*;
#(
    parameter int RTO = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = $clog2(RTO + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + W'(1);
    end

    assign o_expire = r_cnt == W'(RTO);
endmodule

// File: rtl/tcp_sender.sv
// tcp_sender: mod-8 go-back-N transmitter that segments user byte counts within the advertised
// window and probes a zero window after RTO cycles.
module tcp_sender
    import tcp_pkg::*;
#(
    parameter int SEQ_W    = TCP_SEQ_W,
    parameter int MAX_SEG  = 4,
    parameter int INIT_WND = 4,
    parameter int RTO      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             app_val,
    input  logic [SEQ_W-1:0] app_len,
    output logic             app_rdy,
    output logic             seg_val,
    output logic [SEQ_W-1:0] seg_seq,
    output logic [SEQ_W-1:0] seg_len,
    input  logic             rcv_ack,
    input  logic [SEQ_W-1:0] rcv_seq,
    input  logic [SEQ_W-1:0] rcv_buff,
    output logic [SEQ_W-1:0] snd_una,
    output logic [SEQ_W-1:0] snd_nxt,
    output logic [SEQ_W-1:0] retx_cnt
);
    localparam logic [SEQ_W-1:0] L_MAX_SEG  = SEQ_W'(MAX_SEG);
    localparam logic [SEQ_W-1:0] L_INIT_WND = SEQ_W'(INIT_WND);
    localparam logic [SEQ_W-1:0] L_ONE      = SEQ_W'(1);

    snd_state_t       r_state, w_state_nxt;
    logic [SEQ_W-1:0] r_una, r_nxt, r_wnd, r_retx, r_seg_seq, r_seg_len;
    logic [SEQ_W:0]   r_pend;
    logic             r_seg_val;

    logic [SEQ_W-1:0] w_infl, w_usable, w_cap, w_len, w_ack_dist, w_wnd_new;
    logic [SEQ_W:0]   w_add, w_sub;
    logic             w_ack_ok, w_tmr_en, w_tmr_clr, w_expire, w_timeout, w_probe;
    logic             w_send, w_accept;

    assign w_infl     = seq_diff(r_nxt, r_una);
    assign w_usable   = (r_wnd > w_infl) ? r_wnd - w_infl : '0;
    assign w_cap      = (w_usable < L_MAX_SEG) ? w_usable : L_MAX_SEG;
    assign w_len      = (r_pend < {1'b0, w_cap}) ? r_pend[SEQ_W-1:0] : w_cap;
    assign w_ack_dist = seq_diff(rcv_seq, r_una);
    assign w_ack_ok   = rcv_ack && (w_ack_dist <= w_infl);
    assign w_wnd_new  = (rcv_buff > WND_MAX) ? WND_MAX : rcv_buff;

    // An acceptable ack in the same cycle suppresses both retransmit and probe.
    assign w_tmr_en  = (w_infl != '0) || (r_state == S_PERSIST);
    assign w_timeout = w_expire && (w_infl != '0) && !w_ack_ok;
    assign w_probe   = w_expire && (r_state == S_PERSIST) && (w_infl == '0) && !w_ack_ok;
    assign w_tmr_clr = w_ack_ok || w_expire || !w_tmr_en;

    assign app_rdy  = r_pend == '0;
    assign w_accept = app_val && app_rdy;
    assign w_send   = (r_state == S_SEND) && (w_len != '0) && !w_timeout;
    assign w_add    = (w_accept ? {1'b0, app_len} : '0) + (w_timeout ? {1'b0, w_infl} : '0);
    assign w_sub    = w_send ? {1'b0, w_len} : {{SEQ_W{1'b0}}, w_probe};

    tcp_snd_timer #(.RTO(RTO)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    w_state_nxt = (r_pend != '0) ? S_SEND : S_IDLE;
            S_SEND:    if (w_len == '0)
                           w_state_nxt = (r_pend == '0) ? ((w_infl == '0) ? S_IDLE : S_WAIT) :
                                         (r_wnd == '0 && w_infl == '0) ? S_PERSIST : S_WAIT;
            S_WAIT:    w_state_nxt = (r_pend != '0 && w_usable != '0) ? S_SEND :
                                     (r_pend != '0 && r_wnd == '0 && w_infl == '0) ? S_PERSIST :
                                     (r_pend == '0 && w_infl == '0) ? S_IDLE : S_WAIT;
            S_PERSIST: w_state_nxt = (w_ack_ok || w_probe) ? S_WAIT : S_PERSIST;
        endcase
        if (w_timeout)
            w_state_nxt = S_SEND;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_una     <= '0;
            r_nxt     <= '0;
            r_wnd     <= L_INIT_WND;
            r_pend    <= '0;
            r_retx    <= '0;
            r_seg_val <= 1'b0;
            r_seg_seq <= '0;
            r_seg_len <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_seg_val <= w_send || w_probe;
            r_seg_seq <= (w_send || w_probe) ? r_nxt : '0;
            r_seg_len <= w_send ? w_len : w_probe ? L_ONE : '0;
            r_nxt     <= w_timeout ? r_una :
                         w_send    ? (r_nxt + w_len) & SEQ_MASK :
                         w_probe   ? (r_nxt + L_ONE) & SEQ_MASK : r_nxt;
            r_pend    <= r_pend + w_add - w_sub;
            r_retx    <= (w_timeout && r_retx != '1) ? r_retx + L_ONE : r_retx;
            if (w_ack_ok) begin
                r_una <= rcv_seq & SEQ_MASK;
                r_wnd <= w_wnd_new;
            end
        end
    end

    assign seg_val  = r_seg_val;
    assign seg_seq  = r_seg_seq;
    assign seg_len  = r_seg_len;
    assign snd_una  = r_una;
    assign snd_nxt  = r_nxt;
    assign retx_cnt = r_retx;
endmodule

// File: tb/tb_tcp_sender.sv
// tb_tcp_sender: directed checks of segmentation, window, go-back-N retransmit, persist probe and reset.
module tb_tcp_sender;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       app_val = 1'b0;
    logic [3:0] app_len = '0;
    logic       app_rdy;
    logic       seg_val;
    logic [3:0] seg_seq, seg_len;
    logic       rcv_ack = 1'b0;
    logic [3:0] rcv_seq = '0;
    logic [3:0] rcv_buff = '0;
    logic [3:0] snd_una, snd_nxt, retx_cnt;

    int checks = 0;
    int failures = 0;
    int n;
    bit got;

    tcp_sender #(.SEQ_W(4), .MAX_SEG(4), .INIT_WND(4), .RTO(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .app_val  (app_val),
        .app_len  (app_len),
        .app_rdy  (app_rdy),
        .seg_val  (seg_val),
        .seg_seq  (seg_seq),
        .seg_len  (seg_len),
        .rcv_ack  (rcv_ack),
        .rcv_seq  (rcv_seq),
        .rcv_buff (rcv_buff),
        .snd_una  (snd_una),
        .snd_nxt  (snd_nxt),
        .retx_cnt (retx_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        app_val = 1'b0;
        rcv_ack = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic offer(input logic [3:0] l);
        app_val = 1'b1;
        app_len = l;
        step();
        app_val = 1'b0;
        app_len = '0;
    endtask

    task automatic ack(input logic [3:0] s, input logic [3:0] b);
        rcv_ack = 1'b1;
        rcv_seq = s;
        rcv_buff = b;
        step();
        rcv_ack = 1'b0;
    endtask

    task automatic wait_seg(input int lim, output int cnt, output bit found);
        found = 1'b0;
        cnt = 0;
        while (!found && cnt < lim) begin
            step();
            cnt++;
            found = seg_val;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst_seg_val", 4'(seg_val), 0);
        chk("rst_seg_seq", seg_seq, 0);
        chk("rst_seg_len", seg_len, 0);
        chk("rst_una", snd_una, 0);
        chk("rst_nxt", snd_nxt, 0);
        chk("rst_retx", retx_cnt, 0);
        chk("rst_app_rdy", 4'(app_rdy), 1);
        rst = 1'b0;

        // 6 bytes into a 4-byte window, then ack opens room for the remainder
        offer(6);
        wait_seg(10, n, got);
        chk("t1_got", 4'(got), 1);
        chk("t1_latency", 4'(n), 2);
        chk("t1_seq", seg_seq, 0);
        chk("t1_len", seg_len, 4);
        chk("t1_nxt", snd_nxt, 4);
        chk("t1_app_rdy_busy", 4'(app_rdy), 0);
        step();
        chk("t1_one_cycle", 4'(seg_val), 0);
        step();
        chk("t1_window_full", 4'(seg_val), 0);
        ack(4, 4);
        wait_seg(10, n, got);
        chk("t1b_got", 4'(got), 1);
        chk("t1b_latency", 4'(n), 2);
        chk("t1b_seq", seg_seq, 4);
        chk("t1b_len", seg_len, 2);
        chk("t1b_nxt", snd_nxt, 6);
        chk("t1b_una", snd_una, 4);
        chk("t1b_app_rdy", 4'(app_rdy), 1);

        // window 8, back-to-back segments wrapping the sequence space
        ack(6, 8);
        chk("t2_una", snd_una, 6);
        offer(5);
        wait_seg(10, n, got);
        chk("t2_got", 4'(got), 1);
        chk("t2_latency", 4'(n), 2);
        chk("t2_seq", seg_seq, 6);
        chk("t2_len", seg_len, 4);
        step();
        chk("t2b_val", 4'(seg_val), 1);
        chk("t2b_seq", seg_seq, 2);
        chk("t2b_len", seg_len, 1);
        chk("t2b_nxt", snd_nxt, 3);

        // timeout retransmit, then an ack in time prevents a second one
        do_reset();
        offer(3);
        wait_seg(10, n, got);
        chk("t3_got", 4'(got), 1);
        chk("t3_seq", seg_seq, 0);
        chk("t3_len", seg_len, 3);
        wait_seg(20, n, got);
        chk("t3_retx_got", 4'(got), 1);
        chk("t3_retx_delay", 4'(n), 8);
        chk("t3_retx_seq", seg_seq, 0);
        chk("t3_retx_len", seg_len, 3);
        chk("t3_retx_cnt", retx_cnt, 1);
        step();
        step();
        step();
        step();
        ack(3, 4);
        wait_seg(12, n, got);
        chk("t3_no_resend", 4'(got), 0);
        chk("t3_retx_cnt_hold", retx_cnt, 1);
        chk("t3_una", snd_una, 3);
        chk("t3_nxt", snd_nxt, 3);

        // ack acceptance range with four bytes in flight
        do_reset();
        offer(4);
        wait_seg(10, n, got);
        chk("t4_got", 4'(got), 1);
        chk("t4_len", seg_len, 4);
        ack(6, 8);
        chk("t4_ack_beyond", snd_una, 0);
        ack(2, 6);
        chk("t4_ack_partial", snd_una, 2);
        ack(1, 8);
        chk("t4_ack_old", snd_una, 2);
        chk("t4_nxt", snd_nxt, 4);

        // zero window: persist probe after RTO, then reopen
        do_reset();
        offer(6);
        wait_seg(10, n, got);
        chk("t5_got", 4'(got), 1);
        chk("t5_len", seg_len, 4);
        ack(4, 0);
        chk("t5_una", snd_una, 4);
        wait_seg(20, n, got);
        chk("t5_probe_got", 4'(got), 1);
        chk("t5_probe_delay", 4'(n), 8);
        chk("t5_probe_seq", seg_seq, 4);
        chk("t5_probe_len", seg_len, 1);
        chk("t5_probe_nxt", snd_nxt, 5);
        chk("t5_probe_retx", retx_cnt, 0);
        chk("t5_probe_app_rdy", 4'(app_rdy), 0);
        ack(5, 4);
        wait_seg(10, n, got);
        chk("t5b_got", 4'(got), 1);
        chk("t5b_latency", 4'(n), 2);
        chk("t5b_seq", seg_seq, 5);
        chk("t5b_len", seg_len, 1);
        chk("t5b_nxt", snd_nxt, 6);
        chk("t5b_app_rdy", 4'(app_rdy), 1);

        // asynchronous reset while a segment is on the bus
        do_reset();
        offer(3);
        wait_seg(10, n, got);
        chk("t6_got", 4'(got), 1);
        chk("t6_nxt_pre", snd_nxt, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_seg_val", 4'(seg_val), 0);
        chk("t6_seg_seq", seg_seq, 0);
        chk("t6_seg_len", seg_len, 0);
        chk("t6_nxt", snd_nxt, 0);
        chk("t6_una", snd_una, 0);
        chk("t6_app_rdy_rst", 4'(app_rdy), 1);
        step();
        rst = 1'b0;
        step();
        chk("t6_app_rdy", 4'(app_rdy), 1);
        chk("t6_idle", 4'(seg_val), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
